hack_keyboard_ps2: RTL and testbench

HACK_KEYBOARD_PS2 -- requirements
Module: hack_keyboard_ps2

---
 rtl/hack_keyboard_ps2_pkg.sv | 30 +++
 rtl/ps2_hack_keymap.sv | 63 ++++++
 rtl/hack_keyboard_ps2.sv | 141 ++++++++++++++
 tb/tb_hack_keyboard_ps2.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_keyboard_ps2_pkg.sv
// Shared constants for the Hack PS/2 keyboard: frame FSM states, PS/2 prefix
// bytes and the Hack special keycodes.
package hack_keyboard_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  localparam logic [7:0] HACK_NEWLINE   = 8'd128;
  localparam logic [7:0] HACK_BACKSPACE = 8'd129;
  localparam logic [7:0] HACK_LEFT      = 8'd130;
  localparam logic [7:0] HACK_UP        = 8'd131;
  localparam logic [7:0] HACK_RIGHT     = 8'd132;
  localparam logic [7:0] HACK_DOWN      = 8'd133;
  localparam logic [7:0] HACK_HOME      = 8'd134;
  localparam logic [7:0] HACK_END       = 8'd135;
  localparam logic [7:0] HACK_PAGE_UP   = 8'd136;
  localparam logic [7:0] HACK_PAGE_DOWN = 8'd137;
  localparam logic [7:0] HACK_INSERT    = 8'd138;
  localparam logic [7:0] HACK_DELETE    = 8'd139;
  localparam logic [7:0] HACK_ESC       = 8'd140;
  localparam logic [7:0] HACK_F1        = 8'd141;

endpackage

// File: rtl/ps2_hack_keymap.sv
// Combinational PS/2 set-2 scancode to Hack keycode table; unmapped codes give 0.
module ps2_hack_keymap
  import hack_keyboard_ps2_pkg::*;
(
  input  logic [7:0] data_byte,
  input  logic       extended,
  output logic [7:0] keycode
);

  always_comb begin
    // NOTE: default first so every path assigns keycode and no latch is inferred.
    keycode = '0;
    if (extended) begin
      case (data_byte)
        8'h6B:   keycode = HACK_LEFT;
        8'h75:   keycode = HACK_UP;
        8'h74:   keycode = HACK_RIGHT;
        8'h72:   keycode = HACK_DOWN;
        8'h6C:   keycode = HACK_HOME;
        8'h69:   keycode = HACK_END;
        8'h7D:   keycode = HACK_PAGE_UP;
        8'h7A:   keycode = HACK_PAGE_DOWN;
        8'h70:   keycode = HACK_INSERT;
        8'h71:   keycode = HACK_DELETE;
        default: keycode = '0;
      endcase
    end else begin
      case (data_byte)
        8'h1C: keycode = "A";  8'h32: keycode = "B";  8'h21: keycode = "C";
        8'h23: keycode = "D";  8'h24: keycode = "E";  8'h2B: keycode = "F";
        8'h34: keycode = "G";  8'h33: keycode = "H";  8'h43: keycode = "I";
        8'h3B: keycode = "J";  8'h42: keycode = "K";  8'h4B: keycode = "L";
        8'h3A: keycode = "M";  8'h31: keycode = "N";  8'h44: keycode = "O";
        8'h4D: keycode = "P";  8'h15: keycode = "Q";  8'h2D: keycode = "R";
        8'h1B: keycode = "S";  8'h2C: keycode = "T";  8'h3C: keycode = "U";
        8'h2A: keycode = "V";  8'h1D: keycode = "W";  8'h22: keycode = "X";
        8'h35: keycode = "Y";  8'h1A: keycode = "Z";
        8'h45: keycode = "0";  8'h16: keycode = "1";  8'h1E: keycode = "2";
        8'h26: keycode = "3";  8'h25: keycode = "4";  8'h2E: keycode = "5";
        8'h36: keycode = "6";  8'h3D: keycode = "7";  8'h3E: keycode = "8";
        8'h46: keycode = "9";
        8'h29: keycode = " ";
        8'h5A: keycode = HACK_NEWLINE;
        8'h66: keycode = HACK_BACKSPACE;
        8'h76: keycode = HACK_ESC;
        8'h05: keycode = HACK_F1;
        8'h06: keycode = HACK_F1 + 8'd1;
        8'h04: keycode = HACK_F1 + 8'd2;
        8'h0C: keycode = HACK_F1 + 8'd3;
        8'h03: keycode = HACK_F1 + 8'd4;
        8'h0B: keycode = HACK_F1 + 8'd5;
        8'h83: keycode = HACK_F1 + 8'd6;
        8'h0A: keycode = HACK_F1 + 8'd7;
        8'h01: keycode = HACK_F1 + 8'd8;
        8'h09: keycode = HACK_F1 + 8'd9;
        8'h78: keycode = HACK_F1 + 8'd10;
        8'h07: keycode = HACK_F1 + 8'd11;
        default: keycode = '0;
      endcase
    end
  end

endmodule

// File: rtl/hack_keyboard_ps2.sv
// PS/2 keyboard receiver producing the Hack keycode of the held key.
// Define KEYBOARD_EXTENDED_KEYS_EN to decode 0xE0-prefixed (arrow/navigation) keys.
module hack_keyboard_ps2
  import hack_keyboard_ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int WORD_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [WORD_WIDTH-1:0] keycode,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [7:0]            scancode
);

`ifdef KEYBOARD_EXTENDED_KEYS_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          fall;
  frame_state_e  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_ok;
  logic [TW-1:0] to_cnt;
  logic          break_pending, extended;
  logic [7:0]    mapped;
  logic [WORD_WIDTH-1:0] mapped_word;

  // Idle-high presets keep the first post-reset sample from looking like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes the previous stage's old value.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];

  ps2_hack_keymap u_keymap (
    .data_byte (shift),
    .extended  (extended),
    .keycode   (mapped)
  );

  assign mapped_word = WORD_WIDTH'(mapped);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      parity_ok     <= 1'b0;
      to_cnt        <= '0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
      scancode      <= '0;
      keycode       <= '0;
      break_pending <= 1'b0;
      extended      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!data_sync[1]) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              frame_error <= 1'b1;
            end
          end
          ST_DATA: begin
            shift   <= {data_sync[1], shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_ok <= ^{data_sync[1], shift};
            state     <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (data_sync[1] && parity_ok) begin
              frame_valid <= 1'b1;
              scancode    <= shift;
              if (shift == PS2_BREAK) begin
                break_pending <= 1'b1;
              end else if (shift == PS2_EXTEND) begin
                extended <= 1'b1;
              end else begin
                // Without extended support the byte after 0xE0 is swallowed.
                if (EXT_EN || !extended) begin
                  if (break_pending) begin
                    if (mapped_word == keycode) keycode <= '0;
                  end else if (mapped != 8'd0) begin
                    keycode <= mapped_word;
                  end
                end
                break_pending <= 1'b0;
                extended      <= 1'b0;
              end
            end else begin
              frame_error <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TO_LAST) begin
          frame_error <= 1'b1;
          state       <= ST_IDLE;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hack_keyboard_ps2.sv
// Self-checking bench for hack_keyboard_ps2: a key-level model predicts each
// frame's outcome; a monitor checks pulses and held outputs every cycle.
module tb_hack_keyboard_ps2;

  localparam int TO   = 300;
  localparam int HALF = 20;

`ifdef KEYBOARD_EXTENDED_KEYS_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        frame_valid, frame_error;
  logic [7:0]  scancode;

  hack_keyboard_ps2 #(.TIMEOUT_CYCLES(TO), .WORD_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keycode     (keycode),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .scancode    (scancode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Key tables in alphabet / digit / function-key order.
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] fkey_codes [12]  = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                                   8'h01, 8'h09, 8'h78, 8'h07};
  logic [7:0] ext_codes [10]   = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A,
                                   8'h70, 8'h71};

  function automatic logic [15:0] model_map(input logic [7:0] b, input bit ext);
    logic [15:0] r = 16'd0;
    if (ext) begin
      for (int i = 0; i < 10; i++) if (ext_codes[i] == b) r = 16'(130 + i);
    end else begin
      for (int i = 0; i < 26; i++) if (letter_codes[i] == b) r = 16'(65 + i);
      for (int i = 0; i < 10; i++) if (digit_codes[i] == b) r = 16'(48 + i);
      for (int i = 0; i < 12; i++) if (fkey_codes[i] == b) r = 16'(141 + i);
      if (b == 8'h29) r = 16'd32;
      if (b == 8'h5A) r = 16'd128;
      if (b == 8'h66) r = 16'd129;
      if (b == 8'h76) r = 16'd140;
    end
    return r;
  endfunction

  // Key-state model: what the held key and last byte must be after each good frame.
  logic [15:0] m_key = '0;
  logic [7:0]  m_sc  = '0;
  bit          m_brk = 1'b0;
  bit          m_ext = 1'b0;

  task automatic model_rx(input logic [7:0] b);
    logic [15:0] m;
    m_sc = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (EXT_EN || !m_ext) begin
        m = model_map(b, m_ext);
        if (m_brk) begin
          if (m == m_key) m_key = '0;
        end else if (m != 0) begin
          m_key = m;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  typedef struct {
    bit          valid;
    logic [15:0] key;
    logic [7:0]  sc;
  } ev_t;

  ev_t exp_q[$];

  // Monitor: every pulse consumes one expected event; held outputs checked each cycle.
  initial begin
    logic [15:0] held_key = '0;
    logic [7:0]  held_sc  = '0;
    ev_t ev;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_key = '0;
        held_sc  = '0;
      end else begin
        if (frame_valid || frame_error) begin
          check("pulse_exclusive", 32'(frame_valid & frame_error), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, frame_valid, frame_error}, 32'd0);
          end else begin
            ev = exp_q.pop_front();
            check("pulse_kind_valid", 32'(frame_valid), 32'(ev.valid));
            if (ev.valid) begin
              held_key = ev.key;
              held_sc  = ev.sc;
            end
          end
        end
        check("keycode_track", 32'(keycode), 32'(held_key));
        check("scancode_track", 32'(scancode), 32'(held_sc));
      end
    end
  end

  task automatic send_bit(input logic d);
    @(negedge clk);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("event_drain", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic push_error();
    ev_t ev;
    ev.valid = 1'b0;
    ev.key   = m_key;
    ev.sc    = m_sc;
    exp_q.push_back(ev);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0);
    ev_t ev;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    if (bad_par) begin
      push_error();
    end else begin
      model_rx(b);
      ev.valid = 1'b1;
      ev.key   = m_key;
      ev.sc    = m_sc;
      exp_q.push_back(ev);
    end
    send_bit(1'b1);
    wait_idle();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_keycode", 32'(keycode), 32'd0);
    check("reset_scancode", 32'(scancode), 32'd0);
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_error", 32'(frame_error), 32'd0);

    send_frame(8'h1C);
    check("A_keycode", 32'(keycode), 32'd65);
    check("A_scancode", 32'(scancode), 32'h1C);

    send_frame(8'hF0);
    send_frame(8'h1C);
    check("A_release", 32'(keycode), 32'd0);

    send_frame(8'h1C);
    send_frame(8'h32);
    send_frame(8'hF0);
    send_frame(8'h1C);
    check("B_held_after_A_break", 32'(keycode), 32'd66);

    send_frame(8'h5A, 1'b1);
    check("badpar_keycode", 32'(keycode), 32'd66);
    check("badpar_scancode", 32'(scancode), 32'h1C);

    // A lone edge with data high is a bad start bit.
    push_error();
    send_bit(1'b1);
    wait_idle();
    check("badstart_keycode", 32'(keycode), 32'd66);

    // Four bits then silence: the partial frame must time out.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    push_error();
    repeat (TO + 1) @(negedge clk);
    wait_idle();
    send_frame(8'h29);
    check("space_after_timeout", 32'(keycode), 32'd32);
    check("space_scancode", 32'(scancode), 32'h29);

    send_frame(8'hF0);
    send_frame(8'h29);
    check("space_release", 32'(keycode), 32'd0);

    send_frame(8'hE0);
    send_frame(8'h75);
`ifdef KEYBOARD_EXTENDED_KEYS_EN
    check("ext_up_make", 32'(keycode), 32'd131);
`else
    check("ext_up_discarded", 32'(keycode), 32'd0);
`endif
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    check("ext_up_release", 32'(keycode), 32'd0);

    send_frame(8'h0E);
    check("unmapped_ignored", 32'(keycode), 32'd0);
    send_frame(8'h05);
    check("F1", 32'(keycode), 32'd141);
    send_frame(8'h07);
    check("F12", 32'(keycode), 32'd152);
    send_frame(8'h76);
    check("esc", 32'(keycode), 32'd140);
    send_frame(8'h5A);
    send_frame(8'h5A);
    check("enter_repeat", 32'(keycode), 32'd128);

    // Reset one cycle after the 5th bit of a frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_key = '0; m_sc = '0; m_brk = 1'b0; m_ext = 1'b0;
    exp_q.delete();
    check("midreset_keycode", 32'(keycode), 32'd0);
    check("midreset_scancode", 32'(scancode), 32'd0);
    check("midreset_valid", 32'(frame_valid), 32'd0);
    check("midreset_error", 32'(frame_error), 32'd0);
    send_frame(8'h16);
    check("one_after_reset", 32'(keycode), 32'd49);
    check("one_scancode", 32'(scancode), 32'h16);

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
